// File: rtl/packed_array_deserializer.sv
// packed_array_deserializer: bit-serial to packed-array word assembler with valid/ready output
// ports: clk/rst (async, active-high); in_valid/in_bit/in_sync/in_ready serial input;
//        out_valid/out_ready/out_data packed word output; sync_err resync pulse; word_cnt handoffs
module packed_array_deserializer #(
  parameter int ELEM_W    = 2,
  parameter int NUM_ELEM  = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic                             in_bit,
  input  logic                             in_sync,
  output logic                             in_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_ELEM-1:0][ELEM_W-1:0]  out_data,
  output logic                             sync_err,
  output logic [7:0]                       word_cnt
);
  localparam int TOTAL = ELEM_W * NUM_ELEM;
  localparam int CNT_W = TOTAL > 1 ? $clog2(TOTAL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, k, pos;
  logic [TOTAL-1:0] asm_q, asm_d, asm_wr, out_data_q, out_data_d;
  logic asm_full_q, asm_full_d, out_valid_q, out_valid_d, sync_err_q, sync_err_d;
  logic [7:0] word_cnt_q, word_cnt_d;
  logic accept, resync, hs, done;
  always_comb begin
    accept = in_valid && !asm_full_q;
    resync = accept && in_sync;
    hs = out_valid_q && out_ready;
    // a resync restarts the word from a cleared register so no stale partial bits survive
    k = resync ? '0 : bit_cnt_q;
    pos = MSB_FIRST != 0 ? LAST - k : k;
    asm_wr = resync ? '0 : asm_q;
    asm_wr[pos] = in_bit;
    done = accept && k == LAST;
    bit_cnt_d = accept ? (done ? '0 : k + CNT_W'(1)) : bit_cnt_q;
    asm_d = asm_q;
    asm_full_d = asm_full_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d = out_data_q;
    // a held word takes priority; no bit can be accepted while it is held
    if (asm_full_q && hs) begin
      out_data_d = asm_q;
      out_valid_d = 1'b1;
      asm_full_d = 1'b0;
      asm_d = '0;
    end else if (done && (!out_valid_q || out_ready)) begin
      out_data_d = asm_wr;
      out_valid_d = 1'b1;
      asm_d = '0;
    end else if (done) begin
      asm_d = asm_wr;
      asm_full_d = 1'b1;
    end else if (accept) begin
      asm_d = asm_wr;
    end
    sync_err_d = resync && bit_cnt_q != '0;
    word_cnt_d = word_cnt_q + 8'(hs);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      asm_q <= '0;
      asm_full_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      sync_err_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      asm_q <= asm_d;
      asm_full_q <= asm_full_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      sync_err_q <= sync_err_d;
      word_cnt_q <= word_cnt_d;
    end
  end
  assign in_ready = !asm_full_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign sync_err = sync_err_q;
  assign word_cnt = word_cnt_q;
endmodule

// File: tb/tb_packed_array_deserializer.sv
// tb_packed_array_deserializer: directed self-checking bench for packed_array_deserializer
module tb_packed_array_deserializer;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_bit = 1'b0, in_sync = 1'b0, out_ready = 1'b0;
  logic ir0, ov0, se0, ir1, ov1, se1;
  logic [3:0][1:0] od0, od1;
  logic [7:0] wc0, wc1;
  int checks = 0, errors = 0, sync_pulses = 0;
  packed_array_deserializer #(.ELEM_W(2), .NUM_ELEM(4), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sync(in_sync),
    .in_ready(ir0), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .sync_err(se0), .word_cnt(wc0));
  packed_array_deserializer #(.ELEM_W(2), .NUM_ELEM(4), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sync(in_sync),
    .in_ready(ir1), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .sync_err(se1), .word_cnt(wc1));
  always #5 clk = ~clk;
  always @(negedge clk) if (se0) sync_pulses++;
  task automatic send_word(input logic [7:0] w, input logic s);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_bit = w[7-i];
      in_sync = (i == 0) && s;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_sync = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sync_pulses = 0;
  endtask
  task automatic test_reset();
    #2;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov0); end
    checks++; if (od0 !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", od0); end
    checks++; if (se0 !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b expected 0", se0); end
    checks++; if (wc0 !== 8'd0) begin errors++; $display("FAIL reset_word_cnt: got %0d expected 0", wc0); end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", ir0); end
  endtask
  task automatic test_bit_order();
    out_ready = 1'b1;
    send_word(8'hB2, 1'b1);
    checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL msb_out_valid: got %b expected 1", ov0); end
    checks++; if (od0 !== 8'hB2) begin errors++; $display("FAIL msb_out_data: got %h expected b2", od0); end
    checks++; if (od0[3] !== 2'b10 || od0[0] !== 2'b10) begin errors++; $display("FAIL msb_elems: got e3=%b e0=%b expected 10 10", od0[3], od0[0]); end
    checks++; if (od1 !== 8'h4D) begin errors++; $display("FAIL lsb_out_data: got %h expected 4d", od1); end
    checks++; if (od1[0] !== 2'b01 || od1[3] !== 2'b01) begin errors++; $display("FAIL lsb_elems: got e0=%b e3=%b expected 01 01", od1[0], od1[3]); end
    @(posedge clk); #1;
    checks++; if (wc0 !== 8'd1) begin errors++; $display("FAIL msb_word_cnt: got %0d expected 1", wc0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL msb_valid_drop: got %b expected 0", ov0); end
    checks++; if (sync_pulses !== 0) begin errors++; $display("FAIL msb_no_sync_err: got %0d pulses expected 0", sync_pulses); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    send_word(8'hB2, 1'b1);
    checks++; if (od0 !== 8'hB2 || ov0 !== 1'b1) begin errors++; $display("FAIL bp_first: got %h/%b expected b2/1", od0, ov0); end
    send_word(8'h3C, 1'b0);
    checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b expected 0", ir0); end
    checks++; if (od0 !== 8'hB2) begin errors++; $display("FAIL bp_hold: got %h expected b2", od0); end
    in_valid = 1'b1;
    in_bit = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (od0 !== 8'hB2 || ir0 !== 1'b0) begin errors++; $display("FAIL bp_stall: got %h/%b expected b2/0", od0, ir0); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (od0 !== 8'h3C || ov0 !== 1'b1) begin errors++; $display("FAIL bp_replace: got %h/%b expected 3c/1", od0, ov0); end
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL bp_in_ready_back: got %b expected 1", ir0); end
    checks++; if (wc0 !== 8'd1) begin errors++; $display("FAIL bp_word_cnt1: got %0d expected 1", wc0); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (wc0 !== 8'd2 || ov0 !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0d/%b expected 2/0", wc0, ov0); end
  endtask
  task automatic test_resync();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b0;
    in_sync = 1'b1;
    @(posedge clk); #1;
    in_sync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_bit = 1'b0;
      @(posedge clk); #1;
    end
    in_sync = 1'b1;
    in_bit = 1'b1;
    @(posedge clk); #1;
    in_sync = 1'b0;
    checks++; if (se0 !== 1'b1) begin errors++; $display("FAIL resync_pulse: got %b expected 1", se0); end
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (od0 !== 8'hFF || ov0 !== 1'b1) begin errors++; $display("FAIL resync_data: got %h/%b expected ff/1", od0, ov0); end
    checks++; if (sync_pulses !== 1) begin errors++; $display("FAIL resync_once: got %0d pulses expected 1", sync_pulses); end
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    send_word(8'h5A, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_bit = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (ov0 !== 1'b0 || ir0 !== 1'b1 || wc0 !== 8'd0) begin errors++; $display("FAIL rst_mid: got v=%b r=%b c=%0d expected 0 1 0", ov0, ir0, wc0); end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL rst_full_pre: got %b expected 0", ir0); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (ov0 !== 1'b0 || ir0 !== 1'b1 || wc0 !== 8'd0 || od0 !== 8'h00) begin errors++; $display("FAIL rst_full: got v=%b r=%b c=%0d d=%h expected 0 1 0 00", ov0, ir0, wc0, od0); end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send_word(8'h96, 1'b0);
    checks++; if (od0 !== 8'h96 || ov0 !== 1'b1) begin errors++; $display("FAIL rst_next_word: got %h/%b expected 96/1", od0, ov0); end
    @(posedge clk); #1;
  endtask
  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int w = 0; w < 256; w++) begin
      send_word(8'(w * 37 + 5), 1'b0);
      checks++; if (od0 !== 8'(w * 37 + 5) || ov0 !== 1'b1 || ir0 !== 1'b1) begin errors++; $display("FAIL wrap_word%0d: got %h/%b/%b expected %h/1/1", w, od0, ov0, ir0, 8'(w * 37 + 5)); end
      if (w == 127) begin
        checks++; if (wc0 !== 8'd127) begin errors++; $display("FAIL wrap_mid_cnt: got %0d expected 127", wc0); end
      end
    end
    checks++; if (wc0 !== 8'd255) begin errors++; $display("FAIL wrap_pre_cnt: got %0d expected 255", wc0); end
    @(posedge clk); #1;
    checks++; if (wc0 !== 8'd0 || ov0 !== 1'b0) begin errors++; $display("FAIL wrap_cnt: got %0d/%b expected 0/0", wc0, ov0); end
  endtask
  initial begin
    test_reset();
    test_bit_order();
    test_back_to_back();
    test_resync();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
